mul_issue_ctrl: RTL
===================

Name: mul_issue_ctrl

Overview:
Sequencer that shares the ALU's multiply modes between one requester and the register-file write port. It accepts a multiply request (MUL, SMULL, UMULL), drives ALUControl and the operands for a configurable number of cycles, and captures Result, ResultExtra and ALUFlags. It then writes the low word and, for long multiplies, the high word through a single arbitrated register-file write port. It sits between decode and the alu instance in the multicycle core.

Parameters:
EXEC_CYCLES, 1, number of cycles ALU inputs are held before results are captured (must be >= 1)
RA_W, 4, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_op  in  3  100=MUL, 110=SMULL, 111=UMULL
req_a  in  32  operand A
req_b  in  32  operand B
req_rdlo  in  RA_W  destination for the low word (Result)
req_rdhi  in  RA_W  destination for the high word (ResultExtra); ignored for MUL
req_setflags  in  1  update flags on completion
ALUControl  out  3  to alu
SrcA  out  32  to alu A
SrcB  out  32  to alu B
Result  in  32  from alu, low word
ResultExtra  in  32  from alu, high word
ALUFlags  in  4  from alu
rf_we  out  1  write request to the register-file port
rf_wa  out  RA_W  write address
rf_wd  out  32  write data
rf_grant  in  1  port granted this cycle; the write commits when rf_we and rf_grant are both high
flags_we  out  1  flag register write strobe
flags_out  out  4  flags captured from the alu
done  out  1  operation complete
err  out  1  illegal op rejected
busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, all registered fields cleared, and every output 0 except req_ready=1. An operation in progress is dropped with no further rf_we. A write already granted stays committed.
- States: IDLE, EXEC, WR_LO, WR_HI.
- IDLE:
  - req_ready=1; ALUControl=000; SrcA=SrcB=0.
  - On req_valid, latch op, a, b, rdlo, rdhi and setflags.
  - Legal op: go to EXEC and load cnt=EXEC_CYCLES-1.
  - Illegal op: stay in IDLE and pulse err for exactly one cycle, the cycle after acceptance. req_ready stays 1.
- EXEC:
  - ALUControl=op_q, SrcA=a_q, SrcB=b_q, held stable for all EXEC cycles.
  - When cnt==0: capture Result into lo_q, ResultExtra into hi_q and ALUFlags into flg_q, then go to WR_LO. Otherwise decrement cnt.
- WR_LO:
  - rf_we=1, rf_wa=rdlo_q, rf_wd=lo_q. Outputs are held until rf_grant.
  - On grant: MUL goes to IDLE with done; SMULL/UMULL go to WR_HI.
- WR_HI:
  - rf_we=1, rf_wa=rdhi_q, rf_wd=hi_q. Outputs are held until rf_grant.
  - On grant: go to IDLE with done.
- done is combinational and asserts in the cycle the final write is granted. flags_we = done & setflags_q. flags_out = flg_q at all times (0 after reset).
- ALU inputs are 0 outside EXEC, so the alu never sees stale operands.
- Latency with continuous grant:
  - MUL: accept at cycle 0, done at cycle EXEC_CYCLES+1.
  - Long multiplies: done at cycle EXEC_CYCLES+2.
  - Each cycle rf_grant is low adds exactly one cycle.
- Next accept: earliest in the cycle after done (state returns to IDLE, so req_ready=1 then).
- rdlo==rdhi on a long multiply: both writes are issued in order, so the high word is the final register value.
- Operands are not re-sampled after acceptance. Changes on req_* while busy have no effect.

Decomposition:
- Shared package:
  - ALU op constants ALU_MUL=3'b100, ALU_SMULL=3'b110, ALU_UMULL=3'b111
  - is_long_mul helper (op[1])
  - 2-bit state encoding IDLE=00, EXEC=01, WR_LO=10, WR_HI=11
- No sub-module. The alu stays instantiated beside this block at the core level. The bench instantiates both.

Test Plan:
- MUL, a=-2, b=3, rdlo=4, rf_grant=1, EXEC_CYCLES=1 -> one write r4=FFFFFFFA; done at cycle 2; no WR_HI.
- SMULL, a=-5, b=10, rdlo=1, rdhi=2, setflags=1 -> writes r1=FFFFFFCE then r2=FFFFFFFF; done with flags_we at cycle 3; flags_out equals ALUFlags sampled at capture.
- UMULL, a=10, b=45, EXEC_CYCLES=3, rf_grant low for 2 cycles in WR_LO -> r1=000001C2, r2=00000000; rf_wa/rf_wd stable while waiting; done at cycle 7.
- req_op=101 -> err high for one cycle, no rf_we, req_ready stays 1; a following legal MUL is accepted next cycle.
- reset driven low during WR_HI -> outputs 0 immediately; no further writes; after release a new SMULL completes normally.
- Back-to-back: hold req_valid with two UMULLs -> second accepted the cycle after first done; req_ready=0 throughout busy; ALUControl=000 in non-EXEC cycles.

Source files
------------

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue sequencer: ALU multiply opcodes,
// state encoding and opcode helpers.
package mul_issue_ctrl_pkg;

    localparam logic [2:0] ALU_NONE  = 3'b000;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_SMULL = 3'b110;
    localparam logic [2:0] ALU_UMULL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_WR_LO = 2'b10,
        ST_WR_HI = 2'b11
    } state_e;

    // Long multiplies produce a second (high) word for the register file.
    function automatic logic is_long_mul(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            ALU_MUL, ALU_SMULL, ALU_UMULL: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// Multiply issue sequencer: holds ALU operands for EXEC_CYCLES, captures the
// product and flags, then writes low/high words through one arbitrated port.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int RA_W        = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [RA_W-1:0] req_rdlo,
    input  logic [RA_W-1:0] req_rdhi,
    input  logic            req_setflags,
    output logic [2:0]      ALUControl,
    output logic [31:0]     SrcA,
    output logic [31:0]     SrcB,
    input  logic [31:0]     Result,
    input  logic [31:0]     ResultExtra,
    input  logic [3:0]      ALUFlags,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_wa,
    output logic [31:0]     rf_wd,
    input  logic            rf_grant,
    output logic            flags_we,
    output logic [3:0]      flags_out,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [RA_W-1:0]   rdlo_q, rdlo_d, rdhi_q, rdhi_d;
    logic              setflags_q, setflags_d;
    logic [31:0]       lo_q, lo_d, hi_q, hi_d;
    logic [3:0]        flg_q, flg_d;
    logic              err_q, err_d;

    // State register and captured request/result fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= 3'b000;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            rdlo_q     <= {RA_W{1'b0}};
            rdhi_q     <= {RA_W{1'b0}};
            setflags_q <= 1'b0;
            lo_q       <= 32'h0;
            hi_q       <= 32'h0;
            flg_q      <= 4'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rdlo_q     <= rdlo_d;
            rdhi_q     <= rdhi_d;
            setflags_q <= setflags_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            flg_q      <= flg_d;
            err_q      <= err_d;
        end
    end

    // Next-state and output decode; ALU inputs are zero outside EXEC.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rdlo_d     = rdlo_q;
        rdhi_d     = rdhi_q;
        setflags_d = setflags_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        flg_d      = flg_q;
        err_d      = 1'b0;
        req_ready  = 1'b0;
        ALUControl = ALU_NONE;
        SrcA       = 32'h0;
        SrcB       = 32'h0;
        rf_we      = 1'b0;
        rf_wa      = {RA_W{1'b0}};
        rf_wd      = 32'h0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d       = req_op;
                    a_d        = req_a;
                    b_d        = req_b;
                    rdlo_d     = req_rdlo;
                    rdhi_d     = req_rdhi;
                    setflags_d = req_setflags;
                    if (is_legal_op(req_op)) begin
                        state_d = ST_EXEC;
                        cnt_d   = CNT_INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                ALUControl = op_q;
                SrcA       = a_q;
                SrcB       = b_q;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    lo_d    = Result;
                    hi_d    = ResultExtra;
                    flg_d   = ALUFlags;
                    state_d = ST_WR_LO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_LO: begin
                rf_we = 1'b1;
                rf_wa = rdlo_q;
                rf_wd = lo_q;
                if (rf_grant) begin
                    if (is_long_mul(op_q)) begin
                        state_d = ST_WR_HI;
                    end else begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end
                end else begin
                    state_d = ST_WR_LO;
                end
            end
            ST_WR_HI: begin
                rf_we = 1'b1;
                rf_wa = rdhi_q;
                rf_wd = hi_q;
                if (rf_grant) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else begin
                    state_d = ST_WR_HI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign flags_we  = done & setflags_q;
    assign flags_out = flg_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
